dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
Shares the single-port data RAM (12-bit word address, 32-bit data, synchronous read) between the processor memory stage and one peripheral master, such as the stepper-pattern loader or a debug reader.
- CPU has fixed priority, with a starvation guard: after MAX_WAIT denied cycles the peripheral is forced a slot and the CPU is stalled for that cycle.
- Sits between processor (wren/address_dmem/data/q_dmem) and RAM (wEn/addr/dataIn/dataOut) in the top-level wrapper.

Parameters:
ADDR_W, 12, RAM word-address width
DATA_W, 32, RAM data width
MAX_WAIT, 4, consecutive denied peripheral cycles before a forced grant (range 1..15)

Ports:
clock  in  1  system clock; all state on posedge
reset  in  1  asynchronous, active-low reset (0 = reset)
cpu_req  in  1  CPU memory access this cycle (load or store in memory stage)
cpu_we  in  1  CPU store
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU store data
cpu_rdata  out  DATA_W  read data to CPU; valid the cycle after a granted CPU read
cpu_stall  out  1  CPU denied this cycle; CPU must hold its request unchanged
per_req  in  1  peripheral access request; held until per_gnt
per_we  in  1  peripheral write
per_addr  in  ADDR_W  peripheral word address
per_wdata  in  DATA_W  peripheral write data
per_gnt  out  1  peripheral access accepted this cycle
per_rdata  out  DATA_W  read data to peripheral
per_rvalid  out  1  per_rdata valid (one cycle after a granted peripheral read)
ram_wen  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_din  out  DATA_W  RAM write data
ram_dout  in  DATA_W  RAM read data (registered inside RAM, 1-cycle latency)

Behaviour:
- Grant decision is combinational from the current requests and registered state. RAM-side mux follows the owner.
- Owner rules, evaluated each cycle:
  - Forced: per_req and wait_cnt==MAX_WAIT -> PER owns; cpu_stall=cpu_req.
  - Else if cpu_req -> CPU owns; per_gnt=0.
  - Else if per_req -> PER owns.
  - Else NONE: ram_wen=0, ram_addr=0, ram_din=0.
- wait_cnt (4 bits):
  - Clears to 0 on every per_gnt.
  - Increments on per_req && !per_gnt; saturates at MAX_WAIT.
  - Holds when per_req is low.
- With MAX_WAIT=4 and the CPU requesting every cycle, the peripheral is denied 4 cycles and granted on the 5th.
- Read return:
  - rd_owner register captures {NONE, CPU, PER} for the granted non-write access.
  - per_rvalid = registered (owner==PER && !per_we).
  - cpu_rdata and per_rdata both carry ram_dout directly; only per_rvalid qualifies the peripheral data.
- Writes complete in the grant cycle; no write response.
- A stalled CPU request is re-evaluated next cycle. Forced grant repeats at most once per MAX_WAIT+1 cycles, so CPU throughput is at least MAX_WAIT/(MAX_WAIT+1).
- Reset (asynchronous, active-low):
  - wait_cnt=0, rd_owner=NONE, per_rvalid=0.
  - While reset is low: per_gnt=0, cpu_stall=0, ram_wen=0.
  - Reset mid-read drops the pending per_rvalid; no partial writes are possible because writes are single-cycle.
- Same-address conflict: CPU write and peripheral read to one address in the same cycle are serialized by grant order; no forwarding.

Optional Feature:
ARB_BURST_EN:
- Defined: adds input per_lock. If per_lock is high on a granted peripheral cycle, PER keeps ownership on following cycles while per_req && per_lock, for up to MAX_WAIT beats. During the burst, cpu_stall=cpu_req. Burst-length counter resets on release or on reset.
- Not defined: no per_lock port; every peripheral access is a single arbitrated beat.

Decomposition:
- Package dmem_arb_pkg:
  - owner enum NONE/CPU/PER.
  - Localparams ADDR_W_DEF=12, DATA_W_DEF=32.
  - WAIT_CNT_W=4.
- One sub-module, arb_wait_counter: saturating counter with clear, increment and at_limit outputs. Reused for the burst-length counter.

Test Plan:
- cpu_req=1 read addr 0x010 (RAM holds 0xDEADBEEF), per_req=0 -> ram_addr=0x010, cpu_rdata=0xDEADBEEF next cycle, cpu_stall=0 throughout.
- cpu_req held 1 for 10 cycles, per_req=1 write 0x0A5 <- 0x12345678, MAX_WAIT=4 -> per_gnt first high on cycle 5, cpu_stall high only that cycle, RAM[0x0A5]=0x12345678.
- cpu_req=0, per_req=1 read 0x020 (holds 7) -> per_gnt same cycle, per_rvalid=1 with per_rdata=7 next cycle, wait_cnt stays 0.
- Reset driven low one cycle after a granted peripheral read -> per_rvalid never asserts, wait_cnt=0, ram_wen=0 while reset is low; normal grants resume after release.
- ARB_BURST_EN: per_lock=1 with 3 writes to 0x100..0x102 while cpu_req=1 -> 3 consecutive per_gnt, cpu_stall high for 3 cycles, then CPU regains the RAM.
- Alternating cpu_req and per_req every cycle -> no stalls, wait_cnt never exceeds 1, all reads return correct data.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-RAM arbiter (dmem_arbiter).
// Owner encoding is shared by the grant mux and the read-return tracker.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        PER  = 2'd2
    } owner_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating up-counter with synchronous clear; at_limit_o flags count == LIMIT.
// Used for the peripheral starvation guard and the burst-length limit.
module arb_wait_counter
    import dmem_arb_pkg::*;
#(
    parameter int W     = WAIT_CNT_W,
    parameter int LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_limit_o
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: cnt_d gets a default first so every path assigns it and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit_o = (cnt_q == LIMIT_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-RAM arbiter: CPU has fixed priority, the peripheral gets a forced
// slot after MAX_WAIT denied cycles. Define ARB_BURST_EN to add per_lock bursts.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              per_req,
    input  logic              per_we,
    input  logic [ADDR_W-1:0] per_addr,
    input  logic [DATA_W-1:0] per_wdata,
`ifdef ARB_BURST_EN
    input  logic              per_lock,
`endif
    output logic              per_gnt,
    output logic [DATA_W-1:0] per_rdata,
    output logic              per_rvalid,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    owner_e owner;
    owner_e rd_owner_d;
    owner_e rd_owner_q;
    logic   wait_at_limit;
    logic   burst_hold;
    logic   force_per;

    arb_wait_counter #(
        .W     (WAIT_CNT_W),
        .LIMIT (MAX_WAIT)
    ) u_wait_cnt (
        .clock      (clock),
        .reset      (reset),
        .clr_i      (per_gnt),
        .inc_i      (per_req && !per_gnt),
        .at_limit_o (wait_at_limit)
    );

`ifdef ARB_BURST_EN
    logic lock_beat;
    logic burst_q;
    logic burst_at_limit;

    // A burst continues only right after a locked grant, until the beat limit is reached.
    assign lock_beat  = per_gnt && per_lock;
    assign burst_hold = burst_q && per_req && per_lock && !burst_at_limit;

    arb_wait_counter #(
        .W     (WAIT_CNT_W),
        .LIMIT (MAX_WAIT)
    ) u_burst_cnt (
        .clock      (clock),
        .reset      (reset),
        .clr_i      (!lock_beat),
        .inc_i      (lock_beat),
        .at_limit_o (burst_at_limit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            burst_q <= 1'b0;
        end else begin
            burst_q <= lock_beat;
        end
    end
`else
    assign burst_hold = 1'b0;
`endif

    // Owner is forced idle while reset is asserted so no grant, stall or write escapes.
    always_comb begin
        owner     = NONE;
        cpu_stall = 1'b0;
        force_per = per_req && (wait_at_limit || burst_hold);
        if (!reset) begin
            owner = NONE;
        end else if (force_per) begin
            owner     = PER;
            cpu_stall = cpu_req;
        end else if (cpu_req) begin
            owner = CPU;
        end else if (per_req) begin
            owner = PER;
        end
    end

    assign per_gnt = (owner == PER);

    always_comb begin
        ram_wen  = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        unique case (owner)
            CPU: begin
                ram_wen  = cpu_we;
                ram_addr = cpu_addr;
                ram_din  = cpu_wdata;
            end
            PER: begin
                ram_wen  = per_we;
                ram_addr = per_addr;
                ram_din  = per_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_owner_d = NONE;
        if ((owner == CPU) && !cpu_we) begin
            rd_owner_d = CPU;
        end else if ((owner == PER) && !per_we) begin
            rd_owner_d = PER;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_owner_q <= NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    // RAM output is already registered; both masters see it, only the peripheral gets a valid.
    assign per_rvalid = (rd_owner_q == PER);
    assign cpu_rdata  = ram_dout;
    assign per_rdata  = ram_dout;

endmodule
